// File: rtl/exc_pkg.sv
// Shared constants for the commit-stage exception sequencer: cause codes,
// sequencer states, CP0 Status/Cause bit positions and the EPC helper.
package exc_pkg;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int IP_LO      = 8;
    localparam int IP_HI      = 15;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } exc_state_t;

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] exc_epc(input logic [31:0] pc, input logic in_ds);
        return in_ds ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_prio_sel.sv
// Combinational arbitration of interrupt, slot-0 and slot-1 exception/ERET
// requests; reports the winning event and the per-slot kill flags.
module exc_prio_sel
    import exc_pkg::*;
(
    input  logic        slot0_valid,
    input  logic [31:0] slot0_pc,
    input  logic        slot0_exc,
    input  logic [4:0]  slot0_exc_code,
    input  logic        slot0_in_ds,
    input  logic        slot0_bad_we,
    input  logic [31:0] slot0_badaddr,
    input  logic        slot0_eret,
    input  logic        slot1_valid,
    input  logic [31:0] slot1_pc,
    input  logic        slot1_exc,
    input  logic [4:0]  slot1_exc_code,
    input  logic        slot1_in_ds,
    input  logic        slot1_bad_we,
    input  logic [31:0] slot1_badaddr,
    input  logic        slot1_eret,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    output logic        slot0_event,
    output logic        slot1_event,
    output logic        event_valid,
    output logic        is_eret,
    output logic [4:0]  code,
    output logic [31:0] epc,
    output logic        bd,
    output logic        bad_we,
    output logic [31:0] badaddr
);

    logic int_pend;
    logic s0_int, s0_exc, s0_eret, s1_exc, s1_eret;
    logic unused_cp0;

    assign int_pend = cp0_status[STATUS_IE] & ~cp0_status[STATUS_EXL]
                    & (|(cp0_cause[IP_HI:IP_LO] & cp0_status[IP_HI:IP_LO]));
    assign unused_cp0 = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:16], cp0_cause[7:0]};

    assign s0_int  = int_pend & slot0_valid;
    assign s0_exc  = slot0_valid & slot0_exc;
    assign s0_eret = slot0_valid & slot0_eret;
    assign s1_exc  = slot1_valid & slot1_exc;
    assign s1_eret = slot1_valid & slot1_eret;

    assign slot0_event = s0_int | s0_exc | s0_eret;
    assign slot1_event = s1_exc | s1_eret;

    always_comb begin
        event_valid = 1'b0;
        is_eret     = 1'b0;
        code        = 5'h00;
        epc         = 32'h0;
        bd          = 1'b0;
        bad_we      = 1'b0;
        badaddr     = 32'h0;
        if (s0_int) begin
            event_valid = 1'b1;
            code        = EXC_INT;
            epc         = exc_epc(slot0_pc, slot0_in_ds);
            bd          = slot0_in_ds;
        end else if (s0_exc) begin
            event_valid = 1'b1;
            code        = slot0_exc_code;
            epc         = exc_epc(slot0_pc, slot0_in_ds);
            bd          = slot0_in_ds;
            bad_we      = slot0_bad_we;
            badaddr     = slot0_badaddr;
        end else if (s0_eret) begin
            event_valid = 1'b1;
            is_eret     = 1'b1;
        end else if (s1_exc) begin
            event_valid = 1'b1;
            code        = slot1_exc_code;
            epc         = exc_epc(slot1_pc, slot1_in_ds);
            bd          = slot1_in_ds;
            bad_we      = slot1_bad_we;
            badaddr     = slot1_badaddr;
        end else if (s1_eret) begin
            event_valid = 1'b1;
            is_eret     = 1'b1;
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Commit-stage exception/ERET sequencer: writes CP0 once, flushes the pipe
// for FLUSH_CYCLES cycles, then hands the redirect PC to fetch.
module exc_commit_ctrl
    import exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        slot0_valid,
    input  logic [31:0] slot0_pc,
    input  logic        slot0_exc,
    input  logic [4:0]  slot0_exc_code,
    input  logic        slot0_in_ds,
    input  logic        slot0_bad_we,
    input  logic [31:0] slot0_badaddr,
    input  logic        slot0_eret,
    input  logic        slot1_valid,
    input  logic [31:0] slot1_pc,
    input  logic        slot1_exc,
    input  logic [4:0]  slot1_exc_code,
    input  logic        slot1_in_ds,
    input  logic        slot1_bad_we,
    input  logic [31:0] slot1_badaddr,
    input  logic        slot1_eret,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    output logic        commit_ok0,
    output logic        commit_ok1,
    output logic        has_exp,
    output logic [4:0]  exp_cause_code,
    output logic [31:0] exp_epc,
    output logic        exp_is_in_delayslot,
    output logic        wen_badaddress,
    output logic [31:0] exp_badaddress,
    output logic        eret_clear,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    exc_state_t  state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        slot0_event, slot1_event, event_valid, is_eret, sel_bd, sel_bad_we;
    logic [4:0]  sel_code;
    logic [31:0] sel_epc, sel_badaddr;
    logic        accept;

    exc_prio_sel u_prio (
        .slot0_valid    (slot0_valid),
        .slot0_pc       (slot0_pc),
        .slot0_exc      (slot0_exc),
        .slot0_exc_code (slot0_exc_code),
        .slot0_in_ds    (slot0_in_ds),
        .slot0_bad_we   (slot0_bad_we),
        .slot0_badaddr  (slot0_badaddr),
        .slot0_eret     (slot0_eret),
        .slot1_valid    (slot1_valid),
        .slot1_pc       (slot1_pc),
        .slot1_exc      (slot1_exc),
        .slot1_exc_code (slot1_exc_code),
        .slot1_in_ds    (slot1_in_ds),
        .slot1_bad_we   (slot1_bad_we),
        .slot1_badaddr  (slot1_badaddr),
        .slot1_eret     (slot1_eret),
        .cp0_status     (cp0_status),
        .cp0_cause      (cp0_cause),
        .slot0_event    (slot0_event),
        .slot1_event    (slot1_event),
        .event_valid    (event_valid),
        .is_eret        (is_eret),
        .code           (sel_code),
        .epc            (sel_epc),
        .bd             (sel_bd),
        .bad_we         (sel_bad_we),
        .badaddr        (sel_badaddr)
    );

    assign accept = (state_reg == IDLE) & event_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (event_valid) begin
                    state_next = FLUSH;
                    cnt_next   = 4'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (cnt_reg == 4'd0) state_next = REDIRECT;
                else                 cnt_next   = cnt_reg - 4'd1;
            end
            REDIRECT: begin
                if (redirect_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        commit_ok0     = (state_reg == IDLE) & slot0_valid & ~slot0_event;
        commit_ok1     = (state_reg == IDLE) & slot1_valid & ~slot0_event & ~slot1_event;
        flush          = (state_reg == FLUSH);
        redirect_valid = (state_reg == REDIRECT);
    end

    // CP0 strobes pulse for the single cycle after acceptance; data and target hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            has_exp             <= 1'b0;
            eret_clear          <= 1'b0;
            wen_badaddress      <= 1'b0;
            exp_cause_code      <= 5'h00;
            exp_epc             <= 32'h0;
            exp_is_in_delayslot <= 1'b0;
            exp_badaddress      <= 32'h0;
            redirect_pc         <= 32'h0;
        end else begin
            has_exp        <= accept & ~is_eret;
            eret_clear     <= accept & is_eret;
            wen_badaddress <= accept & ~is_eret & sel_bad_we;
            if (accept) begin
                redirect_pc <= is_eret ? cp0_epc : EXC_VECTOR;
                if (!is_eret) begin
                    exp_cause_code      <= sel_code;
                    exp_epc             <= sel_epc;
                    exp_is_in_delayslot <= sel_bd;
                    exp_badaddress      <= sel_badaddr;
                end
            end
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl: each task drives one scenario and
// checks hand-computed values inline.
module tb_exc_commit_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        slot0_valid, slot0_exc, slot0_in_ds, slot0_bad_we, slot0_eret;
    logic [31:0] slot0_pc, slot0_badaddr;
    logic [4:0]  slot0_exc_code;
    logic        slot1_valid, slot1_exc, slot1_in_ds, slot1_bad_we, slot1_eret;
    logic [31:0] slot1_pc, slot1_badaddr;
    logic [4:0]  slot1_exc_code;
    logic [31:0] cp0_status, cp0_cause, cp0_epc;
    logic        commit_ok0, commit_ok1, has_exp, exp_is_in_delayslot, wen_badaddress;
    logic [4:0]  exp_cause_code;
    logic [31:0] exp_epc, exp_badaddress, redirect_pc;
    logic        eret_clear, flush, redirect_valid, redirect_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exc_commit_ctrl dut (
        .clk                 (clk),
        .resetn              (resetn),
        .slot0_valid         (slot0_valid),
        .slot0_pc            (slot0_pc),
        .slot0_exc           (slot0_exc),
        .slot0_exc_code      (slot0_exc_code),
        .slot0_in_ds         (slot0_in_ds),
        .slot0_bad_we        (slot0_bad_we),
        .slot0_badaddr       (slot0_badaddr),
        .slot0_eret          (slot0_eret),
        .slot1_valid         (slot1_valid),
        .slot1_pc            (slot1_pc),
        .slot1_exc           (slot1_exc),
        .slot1_exc_code      (slot1_exc_code),
        .slot1_in_ds         (slot1_in_ds),
        .slot1_bad_we        (slot1_bad_we),
        .slot1_badaddr       (slot1_badaddr),
        .slot1_eret          (slot1_eret),
        .cp0_status          (cp0_status),
        .cp0_cause           (cp0_cause),
        .cp0_epc             (cp0_epc),
        .commit_ok0          (commit_ok0),
        .commit_ok1          (commit_ok1),
        .has_exp             (has_exp),
        .exp_cause_code      (exp_cause_code),
        .exp_epc             (exp_epc),
        .exp_is_in_delayslot (exp_is_in_delayslot),
        .wen_badaddress      (wen_badaddress),
        .exp_badaddress      (exp_badaddress),
        .eret_clear          (eret_clear),
        .flush               (flush),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .redirect_ready      (redirect_ready)
    );

    task automatic clear_inputs();
        slot0_valid = 0; slot0_exc = 0; slot0_in_ds = 0; slot0_bad_we = 0; slot0_eret = 0;
        slot0_pc = 32'h0; slot0_badaddr = 32'h0; slot0_exc_code = 5'h0;
        slot1_valid = 0; slot1_exc = 0; slot1_in_ds = 0; slot1_bad_we = 0; slot1_eret = 0;
        slot1_pc = 32'h0; slot1_badaddr = 32'h0; slot1_exc_code = 5'h0;
        cp0_status = 32'h0; cp0_cause = 32'h0; cp0_epc = 32'h0;
        redirect_ready = 0;
    endtask

    // From the first flush cycle (T+1): runs flush out, accepts redirect, ends in IDLE.
    task automatic finish_seq();
        @(negedge clk);
        @(negedge clk);
        redirect_ready = 1;
        @(negedge clk);
        redirect_ready = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({has_exp, eret_clear, flush, redirect_valid, wen_badaddress, commit_ok0, commit_ok1} !== 7'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000000",
                {has_exp, eret_clear, flush, redirect_valid, wen_badaddress, commit_ok0, commit_ok1});
        end
        n_checks++;
        if (redirect_pc !== 32'h0) begin
            n_fail++; $display("FAIL reset_redirect_pc: got %h want 00000000", redirect_pc);
        end
        resetn = 1;
        @(negedge clk);
        slot0_valid = 1; slot1_valid = 1;
        #1;
        n_checks++;
        if ({commit_ok0, commit_ok1} !== 2'b11) begin
            n_fail++; $display("FAIL reset_idle_commit: got %b want 11", {commit_ok0, commit_ok1});
        end
        $display("reset: idle commit ok0/ok1=%b%b", commit_ok0, commit_ok1);
        clear_inputs();
    endtask

    task automatic test_adel();
        @(negedge clk);
        slot0_valid = 1; slot0_pc = 32'h8000_1000; slot0_exc = 1; slot0_exc_code = 5'h04;
        slot0_bad_we = 1; slot0_badaddr = 32'h8000_1001;
        slot1_valid = 1; slot1_pc = 32'h8000_1004;
        #1;
        n_checks++;
        if ({commit_ok0, commit_ok1} !== 2'b00) begin
            n_fail++; $display("FAIL adel_commit: got %b want 00", {commit_ok0, commit_ok1});
        end
        @(negedge clk);
        clear_inputs();
        n_checks++;
        if ({has_exp, exp_cause_code, exp_epc, exp_is_in_delayslot, wen_badaddress, exp_badaddress, flush}
            !== {1'b1, 5'h04, 32'h8000_1000, 1'b0, 1'b1, 32'h8000_1001, 1'b1}) begin
            n_fail++; $display("FAIL adel_cp0: got has=%b code=%h epc=%h bd=%b wen=%b bad=%h flush=%b want 1 04 80001000 0 1 80001001 1",
                has_exp, exp_cause_code, exp_epc, exp_is_in_delayslot, wen_badaddress, exp_badaddress, flush);
        end
        @(negedge clk);
        n_checks++;
        if ({has_exp, wen_badaddress, flush, redirect_valid} !== 4'b0010) begin
            n_fail++; $display("FAIL adel_flush2: got %b want 0010", {has_exp, wen_badaddress, flush, redirect_valid});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({flush, redirect_valid, redirect_pc} !== {1'b0, 1'b1, 32'hBFC0_0380}) begin
                n_fail++; $display("FAIL adel_redirect_wait%0d: got flush=%b rv=%b pc=%h want 0 1 bfc00380",
                    i, flush, redirect_valid, redirect_pc);
            end
        end
        redirect_ready = 1;
        @(negedge clk);
        redirect_ready = 0;
        slot0_valid = 1;
        #1;
        n_checks++;
        if ({redirect_valid, commit_ok0} !== 2'b01) begin
            n_fail++; $display("FAIL adel_return_idle: got rv=%b ok0=%b want 0 1", redirect_valid, commit_ok0);
        end
        $display("adel: code=%h epc=%h redirect=%h", exp_cause_code, exp_epc, redirect_pc);
        clear_inputs();
    endtask

    task automatic test_slot1_sys();
        @(negedge clk);
        slot0_valid = 1; slot0_pc = 32'h8000_2000;
        slot1_valid = 1; slot1_pc = 32'h8000_2004; slot1_exc = 1; slot1_exc_code = 5'h08; slot1_in_ds = 1;
        slot1_badaddr = 32'h1234_5678;
        #1;
        n_checks++;
        if ({commit_ok0, commit_ok1} !== 2'b10) begin
            n_fail++; $display("FAIL sys_commit: got %b want 10", {commit_ok0, commit_ok1});
        end
        @(negedge clk);
        clear_inputs();
        n_checks++;
        if ({has_exp, exp_cause_code, exp_epc, exp_is_in_delayslot, wen_badaddress}
            !== {1'b1, 5'h08, 32'h8000_2000, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL sys_cp0: got has=%b code=%h epc=%h bd=%b wen=%b want 1 08 80002000 1 0",
                has_exp, exp_cause_code, exp_epc, exp_is_in_delayslot, wen_badaddress);
        end
        $display("slot1 sys: code=%h epc=%h bd=%b", exp_cause_code, exp_epc, exp_is_in_delayslot);
        finish_seq();
    endtask

    task automatic test_interrupt();
        logic [31:0] status_tab [2];
        logic [4:0]  code_tab [2];
        status_tab[0] = 32'h0000_0401; code_tab[0] = 5'h00;
        status_tab[1] = 32'h0000_0403; code_tab[1] = 5'h0C;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            cp0_status = status_tab[k]; cp0_cause = 32'h0000_0400;
            slot0_valid = 1; slot0_pc = 32'h8000_3000; slot0_exc = 1; slot0_exc_code = 5'h0C;
            slot1_valid = 1; slot1_pc = 32'h8000_3004;
            #1;
            n_checks++;
            if ({commit_ok0, commit_ok1} !== 2'b00) begin
                n_fail++; $display("FAIL int%0d_commit: got %b want 00", k, {commit_ok0, commit_ok1});
            end
            @(negedge clk);
            clear_inputs();
            n_checks++;
            if ({has_exp, exp_cause_code, exp_epc} !== {1'b1, code_tab[k], 32'h8000_3000}) begin
                n_fail++; $display("FAIL int%0d_cp0: got has=%b code=%h epc=%h want 1 %h 80003000",
                    k, has_exp, exp_cause_code, exp_epc, code_tab[k]);
            end
            $display("interrupt case %0d: code=%h epc=%h", k, exp_cause_code, exp_epc);
            finish_seq();
        end
    endtask

    task automatic test_eret();
        @(negedge clk);
        slot0_valid = 1; slot0_pc = 32'h8000_5000; slot0_eret = 1; cp0_epc = 32'h8000_4000;
        @(negedge clk);
        clear_inputs();
        n_checks++;
        if ({eret_clear, has_exp, flush} !== 3'b101) begin
            n_fail++; $display("FAIL eret_pulse: got clr=%b has=%b flush=%b want 1 0 1", eret_clear, has_exp, flush);
        end
        @(negedge clk);
        n_checks++;
        if ({eret_clear, flush, redirect_valid} !== 3'b010) begin
            n_fail++; $display("FAIL eret_flush2: got %b want 010", {eret_clear, flush, redirect_valid});
        end
        @(negedge clk);
        n_checks++;
        if ({flush, redirect_valid, redirect_pc} !== {1'b0, 1'b1, 32'h8000_4000}) begin
            n_fail++; $display("FAIL eret_redirect: got flush=%b rv=%b pc=%h want 0 1 80004000",
                flush, redirect_valid, redirect_pc);
        end
        $display("eret: redirect=%h", redirect_pc);
        redirect_ready = 1;
        @(negedge clk);
        redirect_ready = 0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        slot0_valid = 1; slot0_pc = 32'h8000_6000; slot0_exc = 1; slot0_exc_code = 5'h09;
        @(negedge clk);
        // New faulting instruction and a stray ready while busy.
        slot0_pc = 32'h8000_7000; slot0_exc_code = 5'h0A; slot1_valid = 1; redirect_ready = 1;
        #1;
        n_checks++;
        if ({has_exp, exp_cause_code, commit_ok0, commit_ok1} !== {1'b1, 5'h09, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL b2b_first: got has=%b code=%h ok=%b%b want 1 09 00",
                has_exp, exp_cause_code, commit_ok0, commit_ok1);
        end
        @(negedge clk);
        n_checks++;
        if ({has_exp, flush, commit_ok0, commit_ok1} !== 4'b0100) begin
            n_fail++; $display("FAIL b2b_flush: got %b want 0100", {has_exp, flush, commit_ok0, commit_ok1});
        end
        @(negedge clk);
        n_checks++;
        if ({has_exp, redirect_valid, commit_ok0, commit_ok1, redirect_pc} !== {4'b0100, 32'hBFC0_0380}) begin
            n_fail++; $display("FAIL b2b_redirect: got has=%b rv=%b ok=%b%b pc=%h want 0 1 00 bfc00380",
                has_exp, redirect_valid, commit_ok0, commit_ok1, redirect_pc);
        end
        @(negedge clk);
        clear_inputs();
        n_checks++;
        if ({has_exp, flush, redirect_valid, exp_cause_code} !== {3'b000, 5'h09}) begin
            n_fail++; $display("FAIL b2b_no_second: got has=%b flush=%b rv=%b code=%h want 0 0 0 09",
                has_exp, flush, redirect_valid, exp_cause_code);
        end
        $display("back_to_back: second fault ignored, code=%h", exp_cause_code);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        slot0_valid = 1; slot0_pc = 32'h8000_8000; slot0_exc = 1; slot0_exc_code = 5'h05; slot0_bad_we = 1;
        slot0_badaddr = 32'h8000_8002;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        #2;
        resetn = 0;
        #1;
        n_checks++;
        if ({has_exp, eret_clear, flush, redirect_valid, wen_badaddress, redirect_pc, exp_epc} !== 69'b0) begin
            n_fail++; $display("FAIL rst_mid_clear: got has=%b clr=%b flush=%b rv=%b wen=%b pc=%h epc=%h want all 0",
                has_exp, eret_clear, flush, redirect_valid, wen_badaddress, redirect_pc, exp_epc);
        end
        @(negedge clk);
        resetn = 1;
        slot0_valid = 1; slot0_pc = 32'h8000_9000; slot0_exc = 1; slot0_exc_code = 5'h0A;
        #1;
        n_checks++;
        if ({commit_ok0, redirect_valid, flush} !== 3'b000) begin
            n_fail++; $display("FAIL rst_mid_idle: got ok0=%b rv=%b flush=%b want 0 0 0", commit_ok0, redirect_valid, flush);
        end
        @(negedge clk);
        clear_inputs();
        n_checks++;
        if ({has_exp, exp_cause_code, exp_epc, flush} !== {1'b1, 5'h0A, 32'h8000_9000, 1'b1}) begin
            n_fail++; $display("FAIL rst_mid_accept: got has=%b code=%h epc=%h flush=%b want 1 0a 80009000 1",
                has_exp, exp_cause_code, exp_epc, flush);
        end
        $display("reset mid-sequence: post-reset code=%h", exp_cause_code);
        finish_seq();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_adel();
        test_slot1_sys();
        test_interrupt();
        test_eret();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
